// File: rtl/regfile_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : regfile_arb_pkg                                                 |
// | Purpose  : Shared types and constants for the register-file write arbiter. |
// |            arb_state_t : current owner of the write port (IDLE/OWN_A/OWN_B)|
// |            req_id_t    : requester identifier (REQ_A / REQ_B)              |
// |            WORD_ALIGN_MASK : low address bits that must be zero for a word |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package regfile_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } arb_state_t;

   typedef logic req_id_t;

   localparam req_id_t    REQ_A           = 1'b0;
   localparam req_id_t    REQ_B           = 1'b1;
   localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

endpackage : regfile_arb_pkg
`default_nettype wire

// File: rtl/regfile_write_arbiter_rr_pick2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rr_pick2                                                        |
// | Purpose  : Combinational two-way round-robin pick with bounded burst.      |
// | Ports    : a_valid_i, b_valid_i  - requester pending flags                 |
// |            state_i               - current owner                           |
// |            burst_max_i           - owner has used its full burst           |
// |            last_served_i         - requester that transferred most recently|
// |            grant_a_o, grant_b_o  - one-hot (or zero) grant                 |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module rr_pick2
   import regfile_arb_pkg::*;
(
   input  logic       a_valid_i,
   input  logic       b_valid_i,
   input  arb_state_t state_i,
   input  logic       burst_max_i,
   input  req_id_t    last_served_i,
   output logic       grant_a_o,
   output logic       grant_b_o
);

   always_comb begin
      grant_a_o = 1'b0;
      grant_b_o = 1'b0;
      if (a_valid_i && b_valid_i) begin
         // Contention: an owner keeps the port until its burst is used up;
         // with no owner the requester not served last goes first.
         unique case (state_i)
            OWN_A: begin
               grant_a_o = ~burst_max_i;
               grant_b_o =  burst_max_i;
            end
            OWN_B: begin
               grant_b_o = ~burst_max_i;
               grant_a_o =  burst_max_i;
            end
            default: begin
               grant_a_o = (last_served_i == REQ_B);
               grant_b_o = (last_served_i == REQ_A);
            end
         endcase
      end else begin
         // A lone requester always wins, which also covers an owner that
         // drops valid while the other side is waiting.
         grant_a_o = a_valid_i;
         grant_b_o = b_valid_i;
      end
   end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : regfile_write_arbiter                                           |
// | Purpose  : Shares the register-file write port between ALU writeback (A)  |
// |            and load writeback (B). Round-robin with bounded burst, one    |
// |            registered output stage, misaligned word writes dropped.        |
// | Ports    : clk, rst (async, active-high)                                   |
// |            a_valid/a_addr/a_data/a_ready - requester A handshake           |
// |            b_valid/b_addr/b_data/b_ready - requester B handshake           |
// |            stall        - freeze grants and arbitration state              |
// |            RegWrite/write_reg/write_data - registered write port           |
// |            misalign_err - one-cycle pulse for a dropped misaligned write   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module regfile_write_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int ADDR_W    = 5,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 4
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              a_valid,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
   input  logic              stall,
   output logic              RegWrite,
   output logic [ADDR_W-1:0] write_reg,
   output logic [DATA_W-1:0] write_data,
   output logic              misalign_err
);

   localparam int               CNT_W   = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
   localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

   arb_state_t        state_q, state_d;
   logic [CNT_W-1:0]  burst_q, burst_d;
   req_id_t           last_q,  last_d;

   logic              regwrite_q;
   logic [ADDR_W-1:0] wreg_q;
   logic [DATA_W-1:0] wdata_q;
   logic              misalign_q;

   logic              grant_a, grant_b;
   logic              xfer_a,  xfer_b, xfer;
   logic              burst_at_max;
   logic [CNT_W-1:0]  burst_inc;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   logic              sel_aligned;

   assign burst_at_max = (burst_q == MAX_CNT);
   assign burst_inc    = burst_at_max ? burst_q : (burst_q + ONE_CNT);

   rr_pick2 u_pick (
      .a_valid_i     (a_valid),
      .b_valid_i     (b_valid),
      .state_i       (state_q),
      .burst_max_i   (burst_at_max),
      .last_served_i (last_q),
      .grant_a_o     (grant_a),
      .grant_b_o     (grant_b)
   );

   // rst gates ready so a requester never sees a handshake that reset discards.
   assign a_ready = grant_a & ~stall & ~rst;
   assign b_ready = grant_b & ~stall & ~rst;
   assign xfer_a  = a_valid & a_ready;
   assign xfer_b  = b_valid & b_ready;
   assign xfer    = xfer_a | xfer_b;

   // ------------------------------------------------------------------------
   // Arbitration FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         burst_q <= '0;
         last_q  <= REQ_B;
      end else begin
         state_q <= state_d;
         burst_q <= burst_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d = state_q;
      burst_d = burst_q;
      last_d  = last_q;
      if (!stall) begin
         if (xfer_a) begin
            state_d = OWN_A;
            burst_d = (state_q == OWN_A) ? burst_inc : ONE_CNT;
            last_d  = REQ_A;
         end else if (xfer_b) begin
            state_d = OWN_B;
            burst_d = (state_q == OWN_B) ? burst_inc : ONE_CNT;
            last_d  = REQ_B;
         end else begin
            state_d = IDLE;
            burst_d = '0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Output stage
   // ------------------------------------------------------------------------
   assign sel_addr    = xfer_b ? b_addr : a_addr;
   assign sel_data    = xfer_b ? b_data : a_data;
   assign sel_aligned = ((sel_addr[1:0] & WORD_ALIGN_MASK) == 2'b00);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regwrite_q <= 1'b0;
         wreg_q     <= '0;
         wdata_q    <= '0;
         misalign_q <= 1'b0;
      end else if (xfer) begin
         // Misaligned writes still load address/data so the dropped write
         // is visible alongside misalign_err.
         regwrite_q <= sel_aligned;
         misalign_q <= ~sel_aligned;
         wreg_q     <= sel_addr;
         wdata_q    <= sel_data;
      end else begin
         regwrite_q <= 1'b0;
         misalign_q <= 1'b0;
      end
   end

   assign RegWrite     = regwrite_q;
   assign write_reg    = wreg_q;
   assign write_data   = wdata_q;
   assign misalign_err = misalign_q;

endmodule : regfile_write_arbiter
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_regfile_write_arbiter                                        |
// | Purpose  : Directed self-checking bench for regfile_write_arbiter.         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_regfile_write_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        a_valid = 1'b0;
   logic [4:0]  a_addr  = '0;
   logic [31:0] a_data  = '0;
   logic        a_ready;
   logic        b_valid = 1'b0;
   logic [4:0]  b_addr  = '0;
   logic [31:0] b_data  = '0;
   logic        b_ready;
   logic        stall   = 1'b0;
   logic        RegWrite;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic        misalign_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regfile_write_arbiter #(.ADDR_W(5), .DATA_W(32), .MAX_BURST(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .a_valid      (a_valid),
      .a_addr       (a_addr),
      .a_data       (a_data),
      .a_ready      (a_ready),
      .b_valid      (b_valid),
      .b_addr       (b_addr),
      .b_data       (b_data),
      .b_ready      (b_ready),
      .stall        (stall),
      .RegWrite     (RegWrite),
      .write_reg    (write_reg),
      .write_data   (write_data),
      .misalign_err (misalign_err)
   );

   task automatic do_reset;
      @(negedge clk);
      rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; stall = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset;
      a_valid = 1'b1; b_valid = 1'b1;
      @(negedge clk); #1;
      checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
         errors++; $display("FAIL reset_ready: got a=%b b=%b expected 0 0", a_ready, b_ready);
      end
      checks++; if (RegWrite !== 1'b0 || misalign_err !== 1'b0) begin
         errors++; $display("FAIL reset_flags: got RegWrite=%b misalign=%b expected 0 0", RegWrite, misalign_err);
      end
      checks++; if (write_reg !== 5'd0 || write_data !== 32'd0) begin
         errors++; $display("FAIL reset_regs: got reg=%h data=%h expected 0 0", write_reg, write_data);
      end
      do_reset();
   endtask

   task automatic test_single_write;
      do_reset();
      a_valid = 1'b1; a_addr = 5'h04; a_data = 32'hDEADBEEF;
      #1;
      checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
         errors++; $display("FAIL single_ready: got a=%b b=%b expected 1 0", a_ready, b_ready);
      end
      @(negedge clk);
      a_valid = 1'b0;
      b_valid = 1'b1; b_addr = 5'h1C; b_data = 32'h0BADF00D;
      #1;
      checks++; if (RegWrite !== 1'b1 || write_reg !== 5'h04 || write_data !== 32'hDEADBEEF) begin
         errors++; $display("FAIL single_out: got we=%b reg=%h data=%h expected 1 04 deadbeef", RegWrite, write_reg, write_data);
      end
      checks++; if (b_ready !== 1'b1) begin
         errors++; $display("FAIL top_addr_ready: got %b expected 1", b_ready);
      end
      @(negedge clk);
      b_valid = 1'b0;
      #1;
      checks++; if (RegWrite !== 1'b1 || write_reg !== 5'h1C || write_data !== 32'h0BADF00D) begin
         errors++; $display("FAIL top_addr_out: got we=%b reg=%h data=%h expected 1 1c 0badf00d", RegWrite, write_reg, write_data);
      end
      @(negedge clk); #1;
      checks++; if (RegWrite !== 1'b0 || write_reg !== 5'h1C) begin
         errors++; $display("FAIL idle_hold: got we=%b reg=%h expected 0 1c", RegWrite, write_reg);
      end
   endtask

   task automatic test_round_robin;
      logic exp_a, prev_a;
      do_reset();
      a_valid = 1'b1; a_addr = 5'h08; a_data = 32'hAAAA0000;
      b_valid = 1'b1; b_addr = 5'h0C; b_data = 32'hBBBB0000;
      prev_a = 1'b0;
      for (int i = 0; i < 12; i++) begin
         exp_a = (((i / 4) % 2) == 0);
         #1;
         checks++; if (a_ready !== exp_a || b_ready !== ~exp_a) begin
            errors++; $display("FAIL rr_grant[%0d]: got a=%b b=%b expected a=%b b=%b", i, a_ready, b_ready, exp_a, ~exp_a);
         end
         if (i > 0) begin
            checks++; if (RegWrite !== 1'b1 || write_reg !== (prev_a ? 5'h08 : 5'h0C)) begin
               errors++; $display("FAIL rr_out[%0d]: got we=%b reg=%h expected 1 %h", i, RegWrite, write_reg, prev_a ? 5'h08 : 5'h0C);
            end
         end
         prev_a = exp_a;
         @(negedge clk);
      end
      a_valid = 1'b0; b_valid = 1'b0;
   endtask

   task automatic test_misalign;
      do_reset();
      a_valid = 1'b1; a_addr = 5'h06; a_data = 32'h12345678;
      #1;
      checks++; if (a_ready !== 1'b1) begin
         errors++; $display("FAIL misalign_ready: got %b expected 1", a_ready);
      end
      @(negedge clk);
      a_valid = 1'b0;
      #1;
      checks++; if (RegWrite !== 1'b0 || misalign_err !== 1'b1 || write_reg !== 5'h06) begin
         errors++; $display("FAIL misalign_out: got we=%b err=%b reg=%h expected 0 1 06", RegWrite, misalign_err, write_reg);
      end
      @(negedge clk); #1;
      checks++; if (misalign_err !== 1'b0) begin
         errors++; $display("FAIL misalign_pulse: got %b expected 0", misalign_err);
      end
   endtask

   task automatic test_stall;
      logic exp_a;
      do_reset();
      a_valid = 1'b1; a_addr = 5'h08; b_valid = 1'b1; b_addr = 5'h0C;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++; if (a_ready !== 1'b1) begin
            errors++; $display("FAIL stall_pre[%0d]: got a=%b expected 1", i, a_ready);
         end
         @(negedge clk);
      end
      stall = 1'b1;
      for (int s = 0; s < 3; s++) begin
         #1;
         checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            errors++; $display("FAIL stall_ready[%0d]: got a=%b b=%b expected 0 0", s, a_ready, b_ready);
         end
         if (s > 0) begin
            checks++; if (RegWrite !== 1'b0) begin
               errors++; $display("FAIL stall_we[%0d]: got %b expected 0", s, RegWrite);
            end
         end
         @(negedge clk);
      end
      stall = 1'b0;
      #1;
      checks++; if (RegWrite !== 1'b0) begin
         errors++; $display("FAIL stall_release_we: got %b expected 0", RegWrite);
      end
      // Burst count of 2 survives the stall: two more A grants, then B.
      for (int i = 0; i < 4; i++) begin
         exp_a = (i < 2);
         if (i > 0) #1;
         checks++; if (a_ready !== exp_a || b_ready !== ~exp_a) begin
            errors++; $display("FAIL stall_resume[%0d]: got a=%b b=%b expected a=%b", i, a_ready, b_ready, exp_a);
         end
         @(negedge clk);
      end
      a_valid = 1'b0; b_valid = 1'b0;
   endtask

   task automatic test_reset_mid;
      do_reset();
      b_valid = 1'b1; b_addr = 5'h14; b_data = 32'hCAFE0014;
      #1;
      checks++; if (b_ready !== 1'b1) begin
         errors++; $display("FAIL rstmid_ready: got %b expected 1", b_ready);
      end
      @(negedge clk);
      b_valid = 1'b0;
      #1;
      checks++; if (RegWrite !== 1'b1 || write_reg !== 5'h14) begin
         errors++; $display("FAIL rstmid_pre: got we=%b reg=%h expected 1 14", RegWrite, write_reg);
      end
      rst = 1'b1; a_valid = 1'b1; a_addr = 5'h10; a_data = 32'h00000010;
      #1;
      checks++; if (RegWrite !== 1'b0 || write_reg !== 5'h00) begin
         errors++; $display("FAIL rstmid_async: got we=%b reg=%h expected 0 00", RegWrite, write_reg);
      end
      checks++; if (a_ready !== 1'b0) begin
         errors++; $display("FAIL rstmid_ready_gated: got %b expected 0", a_ready);
      end
      @(negedge clk);
      rst = 1'b0; b_valid = 1'b1;
      #1;
      checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
         errors++; $display("FAIL rstmid_tie: got a=%b b=%b expected 1 0", a_ready, b_ready);
      end
      @(negedge clk);
      a_valid = 1'b0; b_valid = 1'b0;
      #1;
      checks++; if (RegWrite !== 1'b1 || write_reg !== 5'h10) begin
         errors++; $display("FAIL rstmid_post: got we=%b reg=%h expected 1 10", RegWrite, write_reg);
      end
   endtask

   task automatic test_owner_drop;
      logic exp_b;
      do_reset();
      a_valid = 1'b1; a_addr = 5'h08; b_valid = 1'b1; b_addr = 5'h0C;
      @(negedge clk);
      @(negedge clk);
      a_valid = 1'b0;
      #1;
      checks++; if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
         errors++; $display("FAIL drop_switch: got a=%b b=%b expected 0 1", a_ready, b_ready);
      end
      @(negedge clk);
      a_valid = 1'b1;
      // B restarted its burst at 1, so three more B grants precede A.
      for (int i = 0; i < 4; i++) begin
         exp_b = (i < 3);
         #1;
         checks++; if (b_ready !== exp_b || a_ready !== ~exp_b) begin
            errors++; $display("FAIL drop_burst[%0d]: got a=%b b=%b expected b=%b", i, a_ready, b_ready, exp_b);
         end
         @(negedge clk);
      end
      a_valid = 1'b0; b_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_round_robin();
      test_misalign();
      test_stall();
      test_reset_mid();
      test_owner_drop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_regfile_write_arbiter
`default_nettype wire
